// File: rtl/shift_normalize.sv
// shift_normalize
//   Two-stage normalizer. Stage 1 captures the operand with its leading-zero
//   count; stage 2 holds the operand shifted left by that count (zero fill)
//   together with the count itself. Valid/retry handshake on both sides,
//   full throughput, no bubbles when the output drains while the input fills.
//
// Parameters
//   Bits            data width; power of two, >= 4
//
// Ports
//   clk             clock, rising edge
//   reset           asynchronous, active-high
//   inp_valid       upstream operand valid
//   inp_retry       upstream transfer refused this cycle
//   inp_a           operand to normalize
//   out_valid       result valid
//   out_retry       downstream refuses the result this cycle
//   out_b           normalized operand
//   out_lz          left-shift amount applied (Bits-1 for a zero operand)
//   out_zero        (only with SHIFT_NORMALIZE_ZERO_FLAG_EN) operand was zero
//
// Build option
//   SHIFT_NORMALIZE_ZERO_FLAG_EN  adds the out_zero output.
module shift_normalize #(
  parameter int Bits = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    inp_valid,
  output logic                    inp_retry,
  input  logic [Bits-1:0]         inp_a,
  output logic                    out_valid,
  input  logic                    out_retry,
  output logic [Bits-1:0]         out_b,
  output logic [$clog2(Bits)-1:0] out_lz
`ifdef SHIFT_NORMALIZE_ZERO_FLAG_EN
  ,
  output logic                    out_zero
`endif
);

  localparam int LzW = $clog2(Bits);

  // Leading-zero count; a zero operand reports Bits-1 so that the shift
  // amount always fits in LzW bits.
  function automatic logic [LzW-1:0] count_lz(input logic [Bits-1:0] a);
    logic [LzW-1:0] n;
    logic           found;
    n     = LzW'(Bits - 1);
    found = 1'b0;
    for (int i = Bits - 1; i >= 0; i--) begin
      if (!found && a[i]) begin
        n     = LzW'(Bits - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic             s1_valid_reg;
  logic [Bits-1:0]  s1_a_reg;
  logic [LzW-1:0]   s1_lz_reg;
  logic             s2_valid_reg;
  logic [Bits-1:0]  s2_b_reg;
  logic [LzW-1:0]   s2_lz_reg;

  logic s2_ready;
  logic s1_advance;
  logic inp_accept;

  // Stage 2 can take a new entry when empty or when its entry leaves now;
  // stage 1 frees up under the same condition, which is what lets a full
  // pipeline move in lock-step without a bubble.
  assign s2_ready   = !s2_valid_reg || !out_retry;
  assign s1_advance = s1_valid_reg && s2_ready;
  assign inp_retry  = s1_valid_reg && !s2_ready;
  assign inp_accept = inp_valid && !inp_retry;

  // Logarithmic barrel shifter: level gi shifts by 2**gi when bit gi of the
  // count is set.
  logic [LzW:0][Bits-1:0] shift_stage;
  assign shift_stage[0] = s1_a_reg;

  for (genvar gi = 0; gi < LzW; gi++) begin : g_shift
    assign shift_stage[gi+1] = s1_lz_reg[gi] ? (shift_stage[gi] << (2**gi))
                                             : shift_stage[gi];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_lz_reg    <= '0;
    end else if (inp_accept) begin
      s1_valid_reg <= 1'b1;
      s1_a_reg     <= inp_a;
      s1_lz_reg    <= count_lz(inp_a);
    end else if (s1_advance) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Data registers only load on advance, so a stalled result stays put.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_reg <= 1'b0;
      s2_b_reg     <= '0;
      s2_lz_reg    <= '0;
    end else if (s1_advance) begin
      s2_valid_reg <= 1'b1;
      s2_b_reg     <= shift_stage[LzW];
      s2_lz_reg    <= s1_lz_reg;
    end else if (s2_valid_reg && !out_retry) begin
      s2_valid_reg <= 1'b0;
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_b     = s2_b_reg;
  assign out_lz    = s2_lz_reg;

`ifdef SHIFT_NORMALIZE_ZERO_FLAG_EN
  logic s2_zero_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_zero_reg <= 1'b0;
    end else if (s1_advance) begin
      s2_zero_reg <= (s1_a_reg == '0);
    end
  end

  assign out_zero = s2_zero_reg;
`endif

endmodule

// File: doc/shift_normalize.md
SHIFT_NORMALIZE -- requirements
Module: shift_normalize

Interface
REQ-001 The module SHALL have parameter Bits, default 64, giving the data width; it must be a power of two and at least 4.
REQ-002 The module SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-004 The module SHALL have port inp_valid, input, width 1: the upstream operand is valid.
REQ-005 The module SHALL have port inp_retry, output, width 1: the upstream transfer is refused this cycle.
REQ-006 The module SHALL have port inp_a, input, width Bits: the operand to normalize.
REQ-007 The module SHALL have port out_valid, output, width 1: the result is valid.
REQ-008 The module SHALL have port out_retry, input, width 1: the downstream stage refuses the result this cycle.
REQ-009 The module SHALL have port out_b, output, width Bits: the normalized operand.
REQ-010 The module SHALL have port out_lz, output, width log2(Bits): the left-shift amount applied.

Function
REQ-011 The module SHALL perform a transfer on either side only in a cycle where valid=1 and retry=0.
REQ-012 The module SHALL be a two-stage pipeline.
- Stage 1 registers inp_a together with its leading-zero count.
- Stage 2 registers out_b = stage-1 operand shifted left by that count, zero-filled, and out_lz = the count.
REQ-013 The leading-zero count SHALL be the number of zero bits above the most significant 1.
- For an all-zero operand, out_lz = Bits-1 and out_b = 0.
REQ-014 Latency SHALL be 2 cycles from an accepted input to out_valid when out_retry=0.
REQ-015 Throughput SHALL be one operand per cycle under sustained inp_valid=1 and out_retry=0.
REQ-016 Under backpressure, stage 2 SHALL hold out_valid, out_b and out_lz stable until the result is accepted.
REQ-017 Stage 1 SHALL advance into stage 2 when stage 2 is empty or is being drained in the same cycle.
REQ-018 inp_retry SHALL equal (stage-1 valid AND stage 1 cannot advance), so a full pipeline absorbs at most 2 results.
- No operand SHALL be dropped.
- No operand SHALL be duplicated.
REQ-019 A simultaneous accept at the input and drain at the output SHALL move every stage by one entry in that cycle with no bubble.
REQ-020 inp_a SHALL be sampled only on an accepted transfer.
- While retry=1, the upstream stage holds inp_a; the block does not latch it.
REQ-021 Stage-valid flags SHALL depend only on the handshake, never on data values.

Reset
REQ-022 While reset=1, stage-1 and stage-2 valid flags SHALL be 0 and out_valid = 0.
REQ-023 While reset=1, inp_retry SHALL be 0 and out_b, out_lz and the stage-1 data registers SHALL be 0.
REQ-024 Reset asserted mid-operation SHALL discard all in-flight operands immediately (asynchronous).
REQ-025 After reset deasserts, the first accepted operand SHALL appear after exactly 2 cycles.

Configuration
REQ-026 With the macro SHIFT_NORMALIZE_ZERO_FLAG_EN defined, the module SHALL add output port out_zero, width 1.
- out_zero is 1 exactly when the stage-2 operand was all zero.
- out_zero is 0 at reset.
- out_zero travels with out_b under the same stall rules.
REQ-027 Without SHIFT_NORMALIZE_ZERO_FLAG_EN, the module SHALL have no out_zero port; all other behaviour is identical.

Verification (Bits=64)
REQ-028 Single operand: inp_a=0x0000_0000_0000_0001, out_retry=0 -> two cycles later out_valid=1, out_b=0x8000_0000_0000_0000, out_lz=63.
REQ-029 Already normalized and zero operands:
- inp_a=0x8000_0000_0000_0000 -> out_b unchanged, out_lz=0.
- inp_a=0 -> out_b=0, out_lz=63, out_zero=1 when SHIFT_NORMALIZE_ZERO_FLAG_EN is defined.
REQ-030 Backpressure: stream 0x10, 0x20, 0x30, 0x40 with out_retry=1 for cycles 2-6.
- inp_retry rises once 2 operands are held.
- out_b/out_lz are stable while stalled.
- After release, results arrive in order with out_lz 59, 58, 58, 57; none lost or duplicated.
REQ-031 Full throughput: 100 random operands back-to-back with out_retry=0 -> one result per cycle, each matching a reference model of clz and shift.
REQ-032 Reset mid-stream: assert reset while both stages are valid -> out_valid=0 and inp_retry=0 in the same cycle.
- No stale result appears after reset deasserts.
- The next operand emerges after 2 cycles.
REQ-033 Random out_retry at 50% with random inp_valid for 10k cycles -> scoreboard reports in-order, exact match and no valid/data change while stalled.
